// File: rtl/npc_multicycle_ctrl_if.sv
// Memory-side handshake bundle for the NPC multi-cycle sequencer:
// instruction-fetch channel and data load/store channel.
interface npc_multicycle_ctrl_if #(
  parameter int unsigned XLEN = 64
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;

  logic            dmem_req_valid;
  logic            dmem_req_ready;
  logic            dmem_req_wen;
  logic            dmem_rsp_valid;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    output dmem_req_valid,
    output dmem_req_wen,
    input  dmem_req_ready,
    input  dmem_rsp_valid
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data,
    input  dmem_req_valid,
    input  dmem_req_wen,
    output dmem_req_ready,
    output dmem_rsp_valid
  );
endinterface

// File: rtl/npc_multicycle_ctrl.sv
// Multi-cycle sequencer for the NPC core: owns PC and instruction register,
// drives imem/dmem handshakes and gates writeback/PC update to one commit per instruction.
module npc_multicycle_ctrl #(
  parameter int unsigned XLEN     = 64,
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter int unsigned RET_W    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  npc_multicycle_ctrl_if.master bus,
  input  logic                  dec_is_load,
  input  logic                  dec_is_store,
  input  logic                  dec_is_ebreak,
  input  logic                  dec_rf_wen,
  input  logic [XLEN-1:0]       exu_nextpc,
  output logic [XLEN-1:0]       pc,
  output logic [31:0]           inst,
  output logic                  rf_wen,
  output logic                  commit,
  output logic                  halted,
  output logic                  misaligned,
  output logic [RET_W-1:0]      retired
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_IWAIT,
    S_EXEC,
    S_MREQ,
    S_MWAIT,
    S_WB,
    S_HALT
  } state_e;

  localparam logic [XLEN-1:0] PC_RST   = XLEN'(RESET_PC);
  localparam logic [31:0]     INST_NOP = 32'h0000_0013;

  state_e           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [31:0]      inst_q, inst_d;
  logic [RET_W-1:0] ret_q, ret_d;
  logic             halted_q, halted_d;
  logic             mis_q, mis_d;

  logic             imem_valid;
  logic             dmem_valid;
  logic             dmem_wen;
  logic             rf_wen_c;
  logic             commit_c;
  logic             pc_aligned;

  assign pc_aligned = (pc_q[1:0] == 2'b00);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    ret_d      = ret_q;
    halted_d   = halted_q;
    mis_d      = mis_q;
    imem_valid = 1'b0;
    dmem_valid = 1'b0;
    dmem_wen   = 1'b0;
    rf_wen_c   = 1'b0;
    commit_c   = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        // A misaligned PC is caught before any request leaves the core.
        if (!pc_aligned) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
          mis_d    = 1'b1;
        end else begin
          imem_valid = 1'b1;
          if (bus.imem_req_ready) begin
            state_d = S_IWAIT;
          end
        end
      end

      S_IWAIT: begin
        if (bus.imem_rsp_valid) begin
          inst_d  = bus.imem_rsp_data;
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        if (dec_is_ebreak) begin
          commit_c = 1'b1;
          ret_d    = ret_q + RET_W'(1);
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else if (dec_is_load || dec_is_store) begin
          state_d = S_MREQ;
        end else begin
          state_d = S_WB;
        end
      end

      S_MREQ: begin
        dmem_valid = 1'b1;
        dmem_wen   = dec_is_store;
        if (bus.dmem_req_ready) begin
          state_d = S_MWAIT;
        end
      end

      S_MWAIT: begin
        if (bus.dmem_rsp_valid) begin
          state_d = S_WB;
        end
      end

      S_WB: begin
        rf_wen_c = dec_rf_wen & ~dec_is_store;
        commit_c = 1'b1;
        pc_d     = exu_nextpc;
        ret_d    = ret_q + RET_W'(1);
        state_d  = S_FETCH;
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_FETCH;
      pc_q     <= PC_RST;
      inst_q   <= INST_NOP;
      ret_q    <= '0;
      halted_q <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      ret_q    <= ret_d;
      halted_q <= halted_d;
      mis_q    <= mis_d;
    end
  end

  // Reset parks the FSM in FETCH; the request must still read as idle while rst is high.
  assign bus.imem_req_valid = imem_valid & ~rst;
  assign bus.imem_req_addr  = pc_q;
  assign bus.dmem_req_valid = dmem_valid;
  assign bus.dmem_req_wen   = dmem_wen;

  assign pc         = pc_q;
  assign inst       = inst_q;
  assign rf_wen     = rf_wen_c;
  assign commit     = commit_c;
  assign halted     = halted_q;
  assign misaligned = mis_q;
  assign retired    = ret_q;

endmodule

// File: tb/tb_npc_multicycle_ctrl.sv
// Directed bench for npc_multicycle_ctrl: per-cycle comparison against a transaction-level
// model of fetch/exec/memory/commit, plus literal latency and boundary expectations.
module tb_npc_multicycle_ctrl;

  localparam int unsigned XLEN   = 64;
  localparam logic [63:0] RST_PC = 64'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #10 clk = ~clk;

  npc_multicycle_ctrl_if #(.XLEN(XLEN)) bus  ();
  npc_multicycle_ctrl_if #(.XLEN(XLEN)) bus4 ();

  logic            dec_is_load, dec_is_store, dec_is_ebreak, dec_rf_wen;
  logic [XLEN-1:0] exu_nextpc;

  logic [XLEN-1:0] pc;
  logic [31:0]     inst;
  logic            rf_wen, commit, halted, misaligned;
  logic [63:0]     retired;

  logic [XLEN-1:0] pc4;
  logic [31:0]     inst4;
  logic            rf_wen4, commit4, halted4, mis4;
  logic [3:0]      retired4;

  npc_multicycle_ctrl #(.XLEN(XLEN), .RESET_PC(RST_PC), .RET_W(64)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .dec_is_load(dec_is_load), .dec_is_store(dec_is_store),
    .dec_is_ebreak(dec_is_ebreak), .dec_rf_wen(dec_rf_wen),
    .exu_nextpc(exu_nextpc),
    .pc(pc), .inst(inst), .rf_wen(rf_wen), .commit(commit),
    .halted(halted), .misaligned(misaligned), .retired(retired)
  );

  // Narrow-counter build sees identical stimulus to exercise retired wrap-around.
  assign bus4.imem_req_ready = bus.imem_req_ready;
  assign bus4.imem_rsp_valid = bus.imem_rsp_valid;
  assign bus4.imem_rsp_data  = bus.imem_rsp_data;
  assign bus4.dmem_req_ready = bus.dmem_req_ready;
  assign bus4.dmem_rsp_valid = bus.dmem_rsp_valid;

  npc_multicycle_ctrl #(.XLEN(XLEN), .RESET_PC(RST_PC), .RET_W(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4),
    .dec_is_load(dec_is_load), .dec_is_store(dec_is_store),
    .dec_is_ebreak(dec_is_ebreak), .dec_rf_wen(dec_rf_wen),
    .exu_nextpc(exu_nextpc),
    .pc(pc4), .inst(inst4), .rf_wen(rf_wen4), .commit(commit4),
    .halted(halted4), .misaligned(mis4), .retired(retired4)
  );

  int total = 0;
  int bad   = 0;
  int unsigned cyc = 0;
  int unsigned last_commit = 0;
  bit chk_en = 1'b0;

  // Architectural model state and this cycle's expected handshake/pulse outputs.
  logic [63:0] m_pc;
  logic [31:0] m_inst;
  logic [63:0] m_ret;
  bit          m_halt, m_mis;
  bit          e_ivalid, e_dvalid, e_wen, e_rfw, e_commit;
  bit          pend_commit, pend_halt, pend_mis;
  logic [63:0] pend_pc;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic clear_inputs();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'hDEAD_BEEF;
    bus.dmem_req_ready = 1'b0;
    bus.dmem_rsp_valid = 1'b0;
  endtask

  // Advance one clock; effects of last cycle's commit/halt become architecturally visible.
  task automatic new_cycle();
    @(negedge clk);
    cyc++;
    if (pend_commit) begin
      m_ret++;
      m_pc = pend_pc;
      pend_commit = 1'b0;
    end
    if (pend_halt) begin m_halt = 1'b1; pend_halt = 1'b0; end
    if (pend_mis)  begin m_mis  = 1'b1; pend_mis  = 1'b0; end
    clear_inputs();
    e_ivalid = 1'b0; e_dvalid = 1'b0; e_wen = 1'b0; e_rfw = 1'b0; e_commit = 1'b0;
  endtask

  // Idle cycle with the core in FETCH (ready low) or HALT; noise injects stray responses.
  task automatic fetch_idle(input bit noise);
    new_cycle();
    if (!m_halt && !pend_halt) begin
      if (m_pc[1:0] != 2'b00) begin
        pend_halt = 1'b1;
        pend_mis  = 1'b1;
      end else begin
        e_ivalid = 1'b1;
      end
    end
    if (noise) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = 32'hFFFF_FFFF;
      bus.dmem_req_ready = 1'b1;
      bus.dmem_rsp_valid = 1'b1;
      if (m_halt || pend_halt) bus.imem_req_ready = 1'b1;
    end
  endtask

  task automatic run_inst(input logic [31:0] ins, input bit ld, input bit st, input bit eb,
                          input bit rfw, input logic [63:0] npc,
                          input int unsigned iw, input int unsigned rw,
                          input int unsigned dw, input int unsigned mw,
                          output int unsigned t0);
    t0 = cyc;
    dec_is_load = ld; dec_is_store = st; dec_is_ebreak = eb; dec_rf_wen = rfw;
    exu_nextpc = npc;
    for (int unsigned i = 0; i <= iw; i++) begin
      new_cycle();
      e_ivalid = 1'b1;
      bus.imem_req_ready = (i == iw);
    end
    for (int unsigned i = 0; i <= rw; i++) begin
      new_cycle();
      if (i == rw) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = ins;
      end else begin
        bus.imem_req_ready = 1'b1;
        bus.dmem_rsp_valid = 1'b1;
      end
    end
    new_cycle();
    m_inst = ins;
    if (eb) begin
      e_commit = 1'b1;
      pend_commit = 1'b1;
      pend_pc = m_pc;
      pend_halt = 1'b1;
    end else begin
      if (ld || st) begin
        for (int unsigned i = 0; i <= dw; i++) begin
          new_cycle();
          e_dvalid = 1'b1;
          e_wen = st;
          bus.dmem_req_ready = (i == dw);
        end
        for (int unsigned i = 0; i <= mw; i++) begin
          new_cycle();
          bus.dmem_rsp_valid = (i == mw);
        end
      end
      new_cycle();
      e_commit = 1'b1;
      e_rfw = rfw && !st;
      pend_commit = 1'b1;
      pend_pc = npc;
    end
  endtask

  // Asynchronous reset asserted mid-cycle; the release cycle is an idle FETCH cycle.
  task automatic do_reset(input bit stale);
    #5;
    chk_en = 1'b0;
    rst = 1'b1;
    clear_inputs();
    #1;
    check("rst_pc", pc, RST_PC);
    check("rst_inst", 64'(inst), 64'(NOP));
    check("rst_retired", retired, 64'd0);
    check("rst_retired4", 64'(retired4), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_misaligned", 64'(misaligned), 64'd0);
    check("rst_imem_valid", 64'(bus.imem_req_valid), 64'd0);
    check("rst_dmem_valid", 64'(bus.dmem_req_valid), 64'd0);
    check("rst_commit", 64'(commit), 64'd0);
    check("rst_rf_wen", 64'(rf_wen), 64'd0);
    m_pc = RST_PC; m_inst = NOP; m_ret = '0; m_halt = 1'b0; m_mis = 1'b0;
    pend_commit = 1'b0; pend_halt = 1'b0; pend_mis = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_hold_imem_valid", 64'(bus.imem_req_valid), 64'd0);
    rst = 1'b0;
    cyc++;
    e_ivalid = 1'b1; e_dvalid = 1'b0; e_wen = 1'b0; e_rfw = 1'b0; e_commit = 1'b0;
    bus.dmem_rsp_valid = stale;
    bus.imem_rsp_valid = stale;
    chk_en = 1'b1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (chk_en) begin
        check("imem_req_valid", 64'(bus.imem_req_valid), 64'(e_ivalid));
        check("imem_req_addr", bus.imem_req_addr, m_pc);
        check("dmem_req_valid", 64'(bus.dmem_req_valid), 64'(e_dvalid));
        if (e_dvalid) check("dmem_req_wen", 64'(bus.dmem_req_wen), 64'(e_wen));
        check("rf_wen", 64'(rf_wen), 64'(e_rfw));
        check("commit", 64'(commit), 64'(e_commit));
        check("pc", pc, m_pc);
        check("inst", 64'(inst), 64'(m_inst));
        check("halted", 64'(halted), 64'(m_halt));
        check("misaligned", 64'(misaligned), 64'(m_mis));
        check("retired", retired, m_ret);
        check("retired4", 64'(retired4), 64'(m_ret[3:0]));
        check("dut4_ctrl",
              64'({bus4.imem_req_valid, bus4.dmem_req_valid, rf_wen4, commit4, halted4, mis4}),
              64'({e_ivalid, e_dvalid, e_rfw, e_commit, m_halt, m_mis}));
        check("dut4_pc", pc4, m_pc);
        check("dut4_addr", bus4.imem_req_addr, m_pc);
        check("dut4_inst", 64'(inst4), 64'(m_inst));
        if (e_dvalid) check("dut4_wen", 64'(bus4.dmem_req_wen), 64'(e_wen));
        if (commit) last_commit = cyc;
      end
    end
  end

  initial begin
    int unsigned t0;
    logic [63:0] npc;
    bit ld, st;

    dec_is_load = 1'b0; dec_is_store = 1'b0; dec_is_ebreak = 1'b0; dec_rf_wen = 1'b0;
    exu_nextpc = '0;
    clear_inputs();
    @(negedge clk);
    do_reset(1'b0);
    #4;
    check("first_fetch_addr", bus.imem_req_addr, 64'h8000_0000);
    check("first_fetch_valid", 64'(bus.imem_req_valid), 64'd1);

    // addi, zero-wait memory
    run_inst(32'h0010_0093, 0, 0, 0, 1, 64'h8000_0004, 0, 0, 0, 0, t0);
    #4;
    check("alu_latency", 64'(last_commit - t0), 64'd4);
    check("alu_rf_wen", 64'(rf_wen), 64'd1);
    fetch_idle(1'b1);
    #4;
    check("alu_pc_after_wb", pc, 64'h8000_0004);
    check("alu_retired", retired, 64'd1);

    // fetch ready stalled 3 cycles, response delayed 2
    run_inst(32'h0020_8113, 0, 0, 0, 1, 64'h8000_0008, 3, 2, 0, 0, t0);
    #4;
    check("stall_latency", 64'(last_commit - t0), 64'd9);
    fetch_idle(1'b0);

    // store with rf_wen requested (must be masked), then load; dmem ready stalled 2
    run_inst(32'h0020_b023, 0, 1, 0, 1, 64'h8000_000C, 0, 0, 2, 0, t0);
    #4;
    check("store_latency", 64'(last_commit - t0), 64'd8);
    check("store_rf_wen", 64'(rf_wen), 64'd0);
    fetch_idle(1'b1);
    run_inst(32'h0000_b183, 1, 0, 0, 1, 64'h8000_0010, 0, 0, 2, 0, t0);
    #4;
    check("load_latency", 64'(last_commit - t0), 64'd8);
    check("load_rf_wen", 64'(rf_wen), 64'd1);
    fetch_idle(1'b0);
    #4;
    check("ldst_retired", retired, 64'd4);

    // mixed traffic up to retired = 15
    for (int unsigned k = 0; k < 11; k++) begin
      ld  = (k % 3 == 1);
      st  = (k % 3 == 2);
      npc = (k == 5) ? m_pc - 64'd16 : m_pc + 64'd4;
      run_inst(NOP + k, ld, st, 0, (k % 4) != 3, npc,
               $urandom_range(0, 2), $urandom_range(0, 2),
               $urandom_range(0, 2), $urandom_range(0, 2), t0);
      fetch_idle(k[0]);
    end
    #4;
    check("retired_15", retired, 64'd15);
    check("retired4_15", 64'(retired4), 64'd15);
    run_inst(NOP, 0, 0, 0, 1, m_pc + 64'd4, 0, 0, 0, 0, t0);
    fetch_idle(1'b0);
    #4;
    check("retired4_wrap", 64'(retired4), 64'd0);
    check("retired_16", retired, 64'd16);

    // reset mid-MWAIT of a load, followed by stale responses
    dec_is_load = 1'b1; dec_is_store = 1'b0; dec_is_ebreak = 1'b0; dec_rf_wen = 1'b1;
    exu_nextpc = 64'h8000_1000;
    new_cycle(); e_ivalid = 1'b1; bus.imem_req_ready = 1'b1;
    new_cycle(); bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h0000_b183;
    new_cycle(); m_inst = 32'h0000_b183;
    new_cycle(); e_dvalid = 1'b1; e_wen = 1'b0; bus.dmem_req_ready = 1'b1;
    new_cycle();
    do_reset(1'b1);
    #4;
    check("abort_retired", retired, 64'd0);
    check("abort_pc", pc, 64'h8000_0000);
    run_inst(32'h0010_0093, 0, 0, 0, 1, 64'h8000_0004, 0, 0, 0, 0, t0);
    fetch_idle(1'b0);
    #4;
    check("post_abort_retired", retired, 64'd1);

    // ebreak: commit in EXEC, then frozen under stray handshakes
    run_inst(32'h0010_0073, 0, 0, 1, 0, 64'h8000_2000, 0, 0, 0, 0, t0);
    #4;
    check("ebreak_latency", 64'(last_commit - t0), 64'd3);
    for (int unsigned i = 0; i < 4; i++) fetch_idle(1'b1);
    #4;
    check("ebreak_halted", 64'(halted), 64'd1);
    check("ebreak_retired", retired, 64'd2);
    check("ebreak_pc", pc, 64'h8000_0004);
    check("ebreak_misaligned", 64'(misaligned), 64'd0);

    // jump to a misaligned target
    do_reset(1'b0);
    run_inst(32'h0010_0093, 0, 0, 0, 1, 64'h8000_0102, 0, 0, 0, 0, t0);
    for (int unsigned i = 0; i < 4; i++) fetch_idle(1'b1);
    #4;
    check("mis_halted", 64'(halted), 64'd1);
    check("mis_flag", 64'(misaligned), 64'd1);
    check("mis_pc", pc, 64'h8000_0102);
    check("mis_retired", retired, 64'd1);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
